// File: rtl/cp0_pc_ctrl.sv
// Coprocessor-0 next-PC and exception/interrupt controller: holds Status, Cause and EPC,
// and picks the fetch address each cycle (reset, exception vector, eret, branch, sequential).
module cp0_pc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_seq,
  input  logic [31:0] pc_branch,
  input  logic        branch_taken,
  input  logic        intr_req,
  input  logic        exc_sys,
  input  logic        exc_unimpl,
  input  logic        exc_ovr,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [1:0]  c0_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] next_pc,
  output logic        intr_ack,
  output logic        exc_taken,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  logic [11:0] status_q, status_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        take_s;
  logic        take_int_s;
  logic [1:0]  code_s;

  // Event qualification and priority: unimpl > sys > ovr > int, all gated by the live mask.
  always_comb begin
    take_s     = 1'b0;
    take_int_s = 1'b0;
    code_s     = 2'd0;
    if (!Clrn) begin
      take_s     = 1'b0;
      take_int_s = 1'b0;
    end else if (exc_unimpl && status_q[2]) begin
      take_s = 1'b1;
      code_s = 2'd2;
    end else if (exc_sys && status_q[1]) begin
      take_s = 1'b1;
      code_s = 2'd1;
    end else if (exc_ovr && status_q[3]) begin
      take_s = 1'b1;
      code_s = 2'd3;
    end else if (intr_req && status_q[0]) begin
      take_s     = 1'b1;
      take_int_s = 1'b1;
      code_s     = 2'd0;
    end else begin
      take_s = 1'b0;
    end
  end

  // Fetch redirect selection.
  always_comb begin
    next_pc = pc_seq;
    if (!Clrn) begin
      next_pc = RESET_PC;
    end else if (take_s) begin
      next_pc = EXC_VECTOR;
    end else if (eret) begin
      next_pc = epc_q;
    end else if (branch_taken) begin
      next_pc = pc_branch;
    end else begin
      next_pc = pc_seq;
    end
  end

  // mfc0 read mux and register views; reads always see the pre-edge value.
  always_comb begin
    status    = {20'd0, status_q};
    cause     = {28'd0, cause_q, 2'd0};
    epc       = epc_q;
    exc_taken = take_s;
    intr_ack  = take_int_s;
    case (c0_sel)
      2'd0:    rdata = {20'd0, status_q};
      2'd1:    rdata = {28'd0, cause_q, 2'd0};
      2'd2:    rdata = epc_q;
      default: rdata = 32'd0;
    endcase
  end

  // Next register state; a taken event overrides any mtc0 in the same cycle.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (take_s) begin
      status_d = {status_q[7:0], 4'd0};
      cause_d  = code_s;
      epc_d    = take_int_s ? pc_seq : pc_cur;
    end else begin
      if (eret) begin
        status_d = {4'd0, status_q[11:4]};
      end else if (mtc0 && (c0_sel == 2'd0)) begin
        status_d = wdata[11:0];
      end else begin
        status_d = status_q;
      end
      if (mtc0 && (c0_sel == 2'd1)) begin
        cause_d = wdata[3:2];
      end else begin
        cause_d = cause_q;
      end
      if (mtc0 && (c0_sel == 2'd2)) begin
        epc_d = wdata;
      end else begin
        epc_d = epc_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      status_q <= 12'd0;
      cause_q  <= 2'd0;
      epc_q    <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_pc_ctrl.sv
// Scoreboard bench for cp0_pc_ctrl: a reference model of Status as a stack of mask nibbles
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_cp0_pc_ctrl;
  localparam logic [31:0] EXC_VEC = 32'h0000_0008;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc_cur, pc_seq, pc_branch;
  logic        branch_taken, intr_req, exc_sys, exc_unimpl, exc_ovr, eret, mtc0;
  logic [1:0]  c0_sel;
  logic [31:0] wdata;
  logic [31:0] rdata, next_pc, status, cause, epc;
  logic        intr_ack, exc_taken;

  always #5 clk = ~clk;

  cp0_pc_ctrl #(.EXC_VECTOR(EXC_VEC), .RESET_PC(RST_PC)) dut (
    .Clk(clk), .Clrn(clrn), .pc_cur(pc_cur), .pc_seq(pc_seq), .pc_branch(pc_branch),
    .branch_taken(branch_taken), .intr_req(intr_req), .exc_sys(exc_sys),
    .exc_unimpl(exc_unimpl), .exc_ovr(exc_ovr), .eret(eret), .mtc0(mtc0),
    .c0_sel(c0_sel), .wdata(wdata), .rdata(rdata), .next_pc(next_pc),
    .intr_ack(intr_ack), .exc_taken(exc_taken), .status(status), .cause(cause), .epc(epc)
  );

  typedef struct {
    logic [31:0] npc;
    logic        exc;
    logic        ack;
    logic        rv;
    logic [31:0] rd;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] ep;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: lvl[0] is the live mask, lvl[1]/lvl[2] the saved copies.
  logic [3:0]  lvl[3];
  logic [1:0]  m_code;
  logic [31:0] m_epc;
  logic        m_known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("next_pc", next_pc, e.npc);
      chk("exc_taken", {31'd0, exc_taken}, {31'd0, e.exc});
      chk("intr_ack", {31'd0, intr_ack}, {31'd0, e.ack});
      if (e.rv) begin
        chk("rdata", rdata, e.rd);
        chk("status", status, e.st);
        chk("cause", cause, e.ca);
        chk("epc", epc, e.ep);
      end
    end
  end

  task automatic idle_in();
    clrn = 1'b1; branch_taken = 1'b0; intr_req = 1'b0; exc_sys = 1'b0;
    exc_unimpl = 1'b0; exc_ovr = 1'b0; eret = 1'b0; mtc0 = 1'b0;
    c0_sel = 2'($urandom_range(0, 3)); wdata = $urandom();
    pc_cur = $urandom() & 32'hFFFF_FFFC; pc_branch = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic step();
    exp_t e;
    int   t;
    pc_seq = pc_cur + 32'd4;
    e.rv  = m_known;
    e.st  = {20'd0, lvl[2], lvl[1], lvl[0]};
    e.ca  = {28'd0, m_code, 2'd0};
    e.ep  = m_epc;
    e.exc = 1'b0;
    e.ack = 1'b0;
    case (c0_sel)
      2'd0:    e.rd = e.st;
      2'd1:    e.rd = e.ca;
      2'd2:    e.rd = e.ep;
      default: e.rd = 32'd0;
    endcase
    if (!clrn) begin
      e.npc = RST_PC;
      for (int i = 0; i < 3; i++) lvl[i] = 4'd0;
      m_code  = 2'd0;
      m_epc   = 32'd0;
      m_known = 1'b1;
    end else begin
      t = 0;
      if (exc_unimpl && lvl[0][2]) t = 1;
      else if (exc_sys && lvl[0][1]) t = 2;
      else if (exc_ovr && lvl[0][3]) t = 3;
      else if (intr_req && lvl[0][0]) t = 4;
      if (t != 0) begin
        e.npc  = EXC_VEC;
        e.exc  = 1'b1;
        e.ack  = (t == 4);
        lvl[2] = lvl[1];
        lvl[1] = lvl[0];
        lvl[0] = 4'd0;
        m_code = (t == 1) ? 2'd2 : (t == 2) ? 2'd1 : (t == 3) ? 2'd3 : 2'd0;
        m_epc  = (t == 4) ? pc_seq : pc_cur;
      end else begin
        if (eret) begin
          e.npc  = m_epc;
          lvl[0] = lvl[1];
          lvl[1] = lvl[2];
          lvl[2] = 4'd0;
        end else if (branch_taken) begin
          e.npc = pc_branch;
        end else begin
          e.npc = pc_seq;
        end
        if (mtc0) begin
          case (c0_sel)
            2'd0: if (!eret) begin
                    lvl[0] = wdata[3:0]; lvl[1] = wdata[7:4]; lvl[2] = wdata[11:8];
                  end
            2'd1: m_code = wdata[3:2];
            2'd2: m_epc = wdata;
            default: ;
          endcase
        end
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr_status(input logic [31:0] v);
    idle_in(); mtc0 = 1'b1; c0_sel = 2'd0; wdata = v; step();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_known = 1'b0;
    m_code  = 2'd0;
    m_epc   = 32'd0;
    for (int i = 0; i < 3; i++) lvl[i] = 4'd0;
    idle_in();
    @(posedge clk);
    #1;
    // Reset held two cycles with events present.
    idle_in(); clrn = 1'b0; intr_req = 1'b1; exc_sys = 1'b1; step();
    idle_in(); clrn = 1'b0; intr_req = 1'b1; exc_sys = 1'b1; step();
    idle_in(); intr_req = 1'b1; exc_sys = 1'b1; step();
    // Syscall and return.
    wr_status(32'hF);
    idle_in(); pc_cur = 32'h40; exc_sys = 1'b1; step();
    idle_in(); eret = 1'b1; step();
    idle_in(); step();
    // Interrupt beats a branch, then stays masked.
    wr_status(32'h1);
    idle_in(); pc_cur = 32'h100; intr_req = 1'b1; branch_taken = 1'b1; step();
    idle_in(); intr_req = 1'b1; step();
    // Priority with a dropped mtc0.
    wr_status(32'hF);
    idle_in(); exc_unimpl = 1'b1; exc_ovr = 1'b1; intr_req = 1'b1;
    mtc0 = 1'b1; c0_sel = 2'd2; step();
    idle_in(); c0_sel = 2'd1; step();
    // Masked overflow.
    wr_status(32'h1);
    idle_in(); exc_ovr = 1'b1; step();
    idle_in(); step();
    // Nesting two deep, then unwind.
    wr_status(32'hF);
    idle_in(); exc_sys = 1'b1; step();
    wr_status(32'hF1);
    idle_in(); intr_req = 1'b1; step();
    idle_in(); eret = 1'b1; step();
    idle_in(); eret = 1'b1; step();
    idle_in(); step();
    // Randomized traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      idle_in();
      clrn         = ($urandom_range(0, 59) != 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      intr_req     = ($urandom_range(0, 2) == 0);
      exc_sys      = ($urandom_range(0, 4) == 0);
      exc_unimpl   = ($urandom_range(0, 5) == 0);
      exc_ovr      = ($urandom_range(0, 4) == 0);
      eret         = ($urandom_range(0, 4) == 0);
      mtc0         = !eret && ($urandom_range(0, 2) == 0);
      if (mtc0 && c0_sel == 2'd0 && $urandom_range(0, 1) == 0) wdata = wdata | 32'hF;
      step();
    end
    idle_in(); step();
    @(negedge clk);
    #1;
    if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
